// File: rtl/prbs_checker_pkg.sv
// Shared FSM encoding and width helpers for the PRBS checker.
package prbs_checker_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_fsm_e;

  // Bits needed to hold a popcount of n bits.
  function automatic int prbs_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed for a run/miss counter that must reach thr.
  function automatic int prbs_thr_w(input int thr);
    return $clog2(thr) + 1;
  endfunction

endpackage

// File: rtl/prbs_checker_lfsr.sv
// Combinational multi-bit LFSR step: Fibonacci or Galois, generator or feed-forward (self-sync) mode.
module prbs_checker_lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

  logic [LFSR_WIDTH-1:0] w_s;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  w_d;
  logic                  w_v;

  // Bit-serial unroll; w_s[0] is the newest bit, w_s[LFSR_WIDTH-1] the oldest.
  always_comb begin
    w_s   = state_in;
    w_out = '0;
    w_d   = 1'b0;
    w_v   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_d = data_in[REVERSE ? i : DATA_WIDTH-1-i];
      w_v = w_s[LFSR_WIDTH-1];
      if (!GALOIS) begin
        for (int j = 1; j < LFSR_WIDTH; j++)
          if (LFSR_POLY[j]) w_v = w_v ^ w_s[j-1];
      end
      w_v = w_v ^ w_d;
      w_out[REVERSE ? i : DATA_WIDTH-1-i] = w_v;
      // Feed-forward shifts in the received bit, so the state rebuilds itself from the line.
      w_s = {w_s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? w_d : w_v)};
      if (GALOIS) begin
        for (int j = 1; j < LFSR_WIDTH; j++)
          if (LFSR_POLY[j]) w_s[j] = w_s[j] ^ (LFSR_FEED_FORWARD ? w_d : w_v);
      end
    end
  end

  assign data_out  = w_out;
  assign state_out = w_s;

endmodule

// File: rtl/prbs_checker.sv
// Receive-side self-synchronising PRBS checker with lock FSM and saturating error/beat totals.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter bit                    LFSR_INVERT   = 1'b1,
  parameter bit                    REVERSE       = 1'b1,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_ERRORS = 4,
  parameter int                    CNT_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_valid,
  input  logic                             clear_counters,
  output logic                             locked,
  output logic                             err_valid,
  output logic [prbs_cw(DATA_WIDTH)-1:0]   err_bits,
  output logic [CNT_WIDTH-1:0]             err_total,
  output logic [CNT_WIDTH-1:0]             beat_total
);

  localparam int CW     = prbs_cw(DATA_WIDTH);
  localparam int RUN_W  = prbs_thr_w(LOCK_COUNT);
  localparam int MISS_W = prbs_thr_w(UNLOCK_ERRORS);

  logic [LFSR_WIDTH-1:0] r_state;
  logic                  r_err_valid;
  logic [CW-1:0]         r_err_bits;
  logic [CNT_WIDTH-1:0]  r_err_total;
  logic [CNT_WIDTH-1:0]  r_beat_total;
  prbs_fsm_e             r_fsm;
  logic [RUN_W-1:0]      r_run;
  logic [MISS_W-1:0]     r_miss;

  logic [DATA_WIDTH-1:0] w_data_in;
  logic [DATA_WIDTH-1:0] w_err_vec;
  logic [LFSR_WIDTH-1:0] w_state_next;
  logic [CW-1:0]         w_pop;
  logic                  w_clean;
  prbs_fsm_e             w_fsm_next;
  logic [RUN_W-1:0]      w_run_next;
  logic [MISS_W-1:0]     w_miss_next;
  logic [CNT_WIDTH:0]    w_err_sum;
  logic [CNT_WIDTH-1:0]  w_err_total_next;
  logic [CNT_WIDTH-1:0]  w_beat_total_next;
  logic                  w_count;

  assign w_data_in = LFSR_INVERT ? ~s_data : s_data;

  prbs_checker_lfsr #(
    .LFSR_WIDTH        (LFSR_WIDTH),
    .LFSR_POLY         (LFSR_POLY),
    .LFSR_CONFIG       ("FIBONACCI"),
    .LFSR_FEED_FORWARD (1'b1),
    .REVERSE           (REVERSE),
    .DATA_WIDTH        (DATA_WIDTH)
  ) u_lfsr (
    .data_in   (w_data_in),
    .state_in  (r_state),
    .data_out  (w_err_vec),
    .state_out (w_state_next)
  );

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_pop = w_pop + CW'(w_err_vec[i]);
  end

  assign w_clean = (w_pop == '0);

  always_comb begin
    w_fsm_next  = r_fsm;
    w_run_next  = r_run;
    w_miss_next = r_miss;
    if (s_valid) begin
      unique case (r_fsm)
        HUNT: begin
          if (w_clean) begin
            w_run_next = r_run + RUN_W'(1);
            if (w_run_next == RUN_W'(LOCK_COUNT)) begin
              w_fsm_next  = LOCKED;
              w_miss_next = '0;
            end
          end else begin
            w_run_next = '0;
          end
        end
        LOCKED: begin
          if (!w_clean) begin
            w_miss_next = r_miss + MISS_W'(1);
            if (w_miss_next == MISS_W'(UNLOCK_ERRORS)) begin
              w_fsm_next = HUNT;
              w_run_next = '0;
            end
          end else begin
            w_miss_next = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm  <= HUNT;
      r_run  <= '0;
      r_miss <= '0;
    end else begin
      r_fsm  <= w_fsm_next;
      r_run  <= w_run_next;
      r_miss <= w_miss_next;
    end
  end

  // Totals are qualified by the state the beat arrived in, so the unlocking beat still counts.
  assign w_count           = s_valid && (r_fsm == LOCKED);
  assign w_err_sum         = {1'b0, r_err_total} + (CNT_WIDTH+1)'(w_pop);
  assign w_err_total_next  = w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];
  assign w_beat_total_next = (&r_beat_total) ? r_beat_total : r_beat_total + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= '0;
      r_err_valid  <= 1'b0;
      r_err_bits   <= '0;
      r_err_total  <= '0;
      r_beat_total <= '0;
    end else begin
      r_err_valid <= s_valid;
      if (s_valid) begin
        r_state    <= w_state_next;
        r_err_bits <= w_pop;
      end
      if (clear_counters) begin
        r_err_total  <= '0;
        r_beat_total <= '0;
      end else if (w_count) begin
        r_err_total  <= w_err_total_next;
        r_beat_total <= w_beat_total_next;
      end
    end
  end

  assign locked     = (r_fsm == LOCKED);
  assign err_valid  = r_err_valid;
  assign err_bits   = r_err_bits;
  assign err_total  = r_err_total;
  assign beat_total = r_beat_total;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: table-driven PRBS31 streams plus hand-built corner sequences.
`timescale 1ns/1ps
module tb_prbs_checker;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int NBITS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          clear_counters;
  logic [DW-1:0] s_data;

  logic          locked, err_valid;
  logic [CW-1:0] err_bits;
  logic [31:0]   err_total, beat_total;

  logic          locked2, err_valid2;
  logic [CW-1:0] err_bits2;
  logic [3:0]    err_total2, beat_total2;

  int n_chk = 0;
  int n_err = 0;

  bit tx [NBITS];

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          exp_vld;
    logic [CW-1:0] exp_bits;
    logic          chk_bits;
    logic          exp_lock;
    logic [31:0]   exp_beats;
  } vec_t;

  vec_t tab1 [40];
  vec_t tab6 [48];

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .clear_counters (clear_counters),
    .locked         (locked),
    .err_valid      (err_valid),
    .err_bits       (err_bits),
    .err_total      (err_total),
    .beat_total     (beat_total)
  );

  // Narrow-counter copy, used to observe saturation.
  prbs_checker #(.CNT_WIDTH(4)) u_sat (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .clear_counters (clear_counters),
    .locked         (locked2),
    .err_valid      (err_valid2),
    .err_bits       (err_bits2),
    .err_total      (err_total2),
    .beat_total     (beat_total2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line word k: PRBS31 bits, inverted on the wire, LSB first.
  function automatic logic [DW-1:0] word(input int k);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = ~tx[DW*k+i];
    return w;
  endfunction

  // Error bits of the first beats after reset: state starts at zero while the seed bits are all ones.
  function automatic logic [CW-1:0] clean_bits(input int j);
    return (j < 3) ? 4'd8 : (j == 3) ? 4'd4 : 4'd0;
  endfunction

  task automatic step(input logic [DW-1:0] d, input logic v, input logic clr);
    s_data         = d;
    s_valid        = v;
    clear_counters = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    step(v.data, v.valid, 1'b0);
    chk({tag, " err_valid"}, 32'(err_valid), 32'(v.exp_vld));
    if (v.chk_bits) chk({tag, " err_bits"}, 32'(err_bits), 32'(v.exp_bits));
    chk({tag, " locked"}, 32'(locked), 32'(v.exp_lock));
    chk({tag, " beat_total"}, beat_total, v.exp_beats);
    chk({tag, " err_total"}, err_total, 32'd0);
  endtask

  initial begin
    int wp;
    int sum;
    int j;

    for (int n = 0; n < NBITS; n++) tx[n] = (n < 31) ? 1'b1 : (tx[n-31] ^ tx[n-28]);

    for (int k = 0; k < 40; k++) begin
      tab1[k].data      = word(k);
      tab1[k].valid     = 1'b1;
      tab1[k].exp_vld   = 1'b1;
      tab1[k].exp_bits  = clean_bits(k);
      tab1[k].chk_bits  = 1'b1;
      tab1[k].exp_lock  = (k >= 19);
      tab1[k].exp_beats = (k >= 20) ? 32'(k - 19) : 32'd0;
    end
    for (int r = 0; r < 48; r++) begin
      j = r / 2;
      tab6[r].data      = (r % 2 == 0) ? word(j) : 8'hA5;
      tab6[r].valid     = (r % 2 == 0);
      tab6[r].exp_vld   = (r % 2 == 0);
      tab6[r].exp_bits  = clean_bits(j);
      tab6[r].chk_bits  = (r % 2 == 0);
      tab6[r].exp_lock  = (j >= 19);
      tab6[r].exp_beats = (j >= 20) ? 32'(j - 19) : 32'd0;
    end

    rst = 1'b1; s_valid = 1'b0; clear_counters = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset err_valid", 32'(err_valid), 32'd0);
    chk("reset err_bits", 32'(err_bits), 32'd0);
    chk("reset err_total", err_total, 32'd0);
    chk("reset beat_total", beat_total, 32'd0);
    rst = 1'b0;

    // Clean stream: lock after beat 20, then one beat counted per beat.
    foreach (tab1[k]) run_vec(tab1[k], "clean");
    chk("sat beat_total", 32'(beat_total2), 32'd15);
    wp = 40;

    // Single flipped line bit while locked.
    sum = 0;
    for (int k = 0; k < 5; k++) begin
      step((k == 0) ? (word(wp) ^ 8'h10) : word(wp), 1'b1, 1'b0);
      wp++;
      chk("flip err_valid", 32'(err_valid), 32'd1);
      sum += int'(err_bits);
    end
    chk("flip err_bits sum", sum, 32'd3);
    chk("flip err_total", err_total, 32'd3);
    chk("flip beat_total", beat_total, 32'd25);
    chk("flip locked", 32'(locked), 32'd1);

    // Clear coincident with an errored beat.
    step(word(wp) ^ 8'h10, 1'b1, 1'b1);
    wp++;
    chk("clr err_total", err_total, 32'd0);
    chk("clr beat_total", beat_total, 32'd0);
    chk("clr locked", 32'(locked), 32'd1);
    chk("clr err_bits", 32'(err_bits), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(word(wp), 1'b1, 1'b0);
      wp++;
    end
    chk("post-clr err_total", err_total, 32'd2);
    chk("post-clr beat_total", beat_total, 32'd4);
    step(word(wp), 1'b1, 1'b0);
    wp++;

    // Corrupted stream: unlock on the 4th errored beat, totals freeze afterwards.
    for (int k = 0; k < 7; k++) begin
      step(~word(wp), 1'b1, 1'b0);
      wp++;
      if (k < 4) chk("garbage err_bits", 32'(err_bits), (k == 3) ? 32'd5 : 32'd8);
      if (k < 3) chk("garbage still locked", 32'(locked), 32'd1);
      if (k == 3) begin
        chk("garbage unlock", 32'(locked), 32'd0);
        chk("garbage beat_total", beat_total, 32'd9);
        chk("garbage err_total", err_total, 32'd31);
      end
    end
    chk("frozen beat_total", beat_total, 32'd9);
    chk("frozen err_total", err_total, 32'd31);
    chk("frozen locked", 32'(locked), 32'd0);
    chk("sat err_total", 32'(err_total2), 32'd15);
    chk("sat beat_total after clr", 32'(beat_total2), 32'd9);

    // All-zero line data never locks.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(8'h00, 1'b1, 1'b0);
      if (k >= 4) chk("zeros err_bits", 32'(err_bits), 32'd8);
      chk("zeros locked", 32'(locked), 32'd0);
    end
    chk("zeros err_total", err_total, 32'd0);
    chk("zeros beat_total", beat_total, 32'd0);

    // Gapped clean stream locks at the same beat count.
    do_reset();
    foreach (tab6[r]) run_vec(tab6[r], "gapped");

    // Reset while locked.
    rst = 1'b1;
    step(word(24), 1'b1, 1'b0);
    rst = 1'b0;
    s_valid = 1'b0;
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst err_valid", 32'(err_valid), 32'd0);
    chk("rst err_bits", 32'(err_bits), 32'd0);
    chk("rst err_total", err_total, 32'd0);
    chk("rst beat_total", beat_total, 32'd0);
    chk("rst narrow outputs", {23'd0, locked2, err_valid2, err_bits2, err_total2, beat_total2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
